// File: rtl/calc_pkg.sv
// Shared constants, key decode and operand-to-BCD helper for the numpad calculator.
package calc_pkg;
  localparam int OPW  = 7;
  localparam int RESW = 14;

  localparam logic [8:0] SC_0 = 9'h070;
  localparam logic [8:0] SC_1 = 9'h069;
  localparam logic [8:0] SC_2 = 9'h072;
  localparam logic [8:0] SC_3 = 9'h07A;
  localparam logic [8:0] SC_4 = 9'h06B;
  localparam logic [8:0] SC_5 = 9'h073;
  localparam logic [8:0] SC_6 = 9'h074;
  localparam logic [8:0] SC_7 = 9'h06C;
  localparam logic [8:0] SC_8 = 9'h075;
  localparam logic [8:0] SC_9 = 9'h07D;
  localparam logic [8:0] SC_ADD   = 9'h079;
  localparam logic [8:0] SC_SUB   = 9'h07B;
  localparam logic [8:0] SC_MUL   = 9'h07C;
  localparam logic [8:0] SC_ENTER = 9'h05A;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;

  localparam logic [2:0] ST_ENTER_A = 3'd0;
  localparam logic [2:0] ST_WAIT_B  = 3'd1;
  localparam logic [2:0] ST_ENTER_B = 3'd2;
  localparam logic [2:0] ST_CALC    = 3'd3;
  localparam logic [2:0] ST_CONV    = 3'd4;
  localparam logic [2:0] ST_SHOW    = 3'd5;

  typedef enum logic [1:0] {KEY_NONE, KEY_DIGIT, KEY_OP, KEY_ENTER} key_kind_e;

  typedef struct packed {
    key_kind_e  kind;
    logic [3:0] digit;
    logic [1:0] op;
  } key_t;

  function automatic key_t decode_key(input logic [8:0] code);
    key_t k;
    k.kind  = KEY_NONE;
    k.digit = 4'd0;
    k.op    = OP_ADD;
    case (code)
      SC_0: begin k.kind = KEY_DIGIT; k.digit = 4'd0; end
      SC_1: begin k.kind = KEY_DIGIT; k.digit = 4'd1; end
      SC_2: begin k.kind = KEY_DIGIT; k.digit = 4'd2; end
      SC_3: begin k.kind = KEY_DIGIT; k.digit = 4'd3; end
      SC_4: begin k.kind = KEY_DIGIT; k.digit = 4'd4; end
      SC_5: begin k.kind = KEY_DIGIT; k.digit = 4'd5; end
      SC_6: begin k.kind = KEY_DIGIT; k.digit = 4'd6; end
      SC_7: begin k.kind = KEY_DIGIT; k.digit = 4'd7; end
      SC_8: begin k.kind = KEY_DIGIT; k.digit = 4'd8; end
      SC_9: begin k.kind = KEY_DIGIT; k.digit = 4'd9; end
      SC_ADD:   begin k.kind = KEY_OP; k.op = OP_ADD; end
      SC_SUB:   begin k.kind = KEY_OP; k.op = OP_SUB; end
      SC_MUL:   begin k.kind = KEY_OP; k.op = OP_MUL; end
      SC_ENTER: k.kind = KEY_ENTER;
      default:  k.kind = KEY_NONE;
    endcase
    return k;
  endfunction

  // v + 6*tens == 16*tens + units, i.e. the packed two-digit BCD of v (v <= 99)
  function automatic logic [7:0] to_bcd2(input logic [OPW-1:0] v);
    logic [OPW-1:0] tens;
    tens = v / OPW'(10);
    return 8'({1'b0, v} + 8'd6 * {1'b0, tens});
  endfunction
endpackage

// File: rtl/calc_sequencer_if.sv
// Key-event input and display/status output bundle of the calculator sequencer.
interface calc_sequencer_if;
  logic [8:0]  last_change;
  logic        key_down_onepulse;
  logic [15:0] disp_bcd;
  logic        disp_neg;
  logic        busy;
  logic        done;
  logic [2:0]  state;

  modport master (
    output last_change, key_down_onepulse,
    input  disp_bcd, disp_neg, busy, done, state
  );

  modport slave (
    input  last_change, key_down_onepulse,
    output disp_bcd, disp_neg, busy, done, state
  );
endinterface

// File: rtl/calc_sequencer_bin2bcd_seq.sv
// Sequential double-dabble: one shift-and-add-3 step per result bit, done exactly 14 cycles after start.
module bin2bcd_seq
  import calc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [RESW-1:0] bin,
  output logic [15:0]     bcd,
  output logic            done
);
  localparam int SHW = 16 + RESW;

  logic [SHW-1:0] sh_q, sh_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           run_q, run_d;
  logic           done_q, done_d;

  function automatic logic [SHW-1:0] dabble(input logic [SHW-1:0] s);
    logic [SHW-1:0] t;
    t = s;
    for (int i = 0; i < 4; i++) begin
      if (t[RESW + 4*i +: 4] >= 4'd5)
        t[RESW + 4*i +: 4] = t[RESW + 4*i +: 4] + 4'd3;
    end
    return {t[SHW-2:0], 1'b0};
  endfunction

  // The start edge itself performs the first step so the 14th lands on cycle start+14.
  always_comb begin
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (start) begin
      sh_d  = dabble({16'd0, bin});
      cnt_d = 4'd1;
      run_d = 1'b1;
    end else if (run_q) begin
      sh_d  = dabble(sh_q);
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'(RESW - 1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign bcd  = sh_q[SHW-1 -: 16];
  assign done = done_q;
endmodule

// File: rtl/calc_sequencer.sv
// Numpad calculator sequencer: operand entry FSM, add/sub/shift-add multiply, BCD conversion for display.
module calc_sequencer
  import calc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  calc_sequencer_if.slave bus
);
  logic [2:0]      state_q, state_d;
  logic [OPW-1:0]  a_q, a_d, b_q, b_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic [RESW-1:0] r_q, r_d;
  logic            neg_q, neg_d;
  logic [2:0]      mul_cnt_q, mul_cnt_d;
  logic            start_q, start_d;
  logic [15:0]     res_bcd_q, res_bcd_d;

  key_t            key;
  logic            key_ev;
  logic [OPW-1:0]  digit_ext;
  logic [15:0]     b2b_bcd;
  logic            b2b_done;
  logic            done_w;

  assign key       = decode_key(bus.last_change);
  assign key_ev    = bus.key_down_onepulse && (key.kind != KEY_NONE);
  assign digit_ext = {3'b000, key.digit};

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (start_q),
    .bin   (r_q),
    .bcd   (b2b_bcd),
    .done  (b2b_done)
  );

  // Keys are only looked at in the entry/show states, so events during CALC/CONV drop out.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    r_d       = r_q;
    neg_d     = neg_q;
    mul_cnt_d = mul_cnt_q;
    start_d   = 1'b0;
    res_bcd_d = res_bcd_q;
    case (state_q)
      ST_ENTER_A: begin
        if (key_ev && key.kind == KEY_DIGIT && cnt_q < 2'd2) begin
          a_d   = a_q * OPW'(10) + digit_ext;
          cnt_d = cnt_q + 2'd1;
        end else if (key_ev && key.kind == KEY_OP && cnt_q != 2'd0) begin
          op_d    = key.op;
          cnt_d   = 2'd0;
          state_d = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (key_ev && key.kind == KEY_DIGIT) begin
          b_d     = digit_ext;
          cnt_d   = 2'd1;
          state_d = ST_ENTER_B;
        end else if (key_ev && key.kind == KEY_OP) begin
          op_d = key.op;
        end
      end
      ST_ENTER_B: begin
        if (key_ev && key.kind == KEY_DIGIT && cnt_q < 2'd2) begin
          b_d   = b_q * OPW'(10) + digit_ext;
          cnt_d = cnt_q + 2'd1;
        end else if (key_ev && key.kind == KEY_ENTER) begin
          r_d       = '0;
          mul_cnt_d = 3'd0;
          state_d   = ST_CALC;
        end
      end
      ST_CALC: begin
        case (op_q)
          OP_MUL: begin
            neg_d     = 1'b0;
            if (b_q[mul_cnt_q])
              r_d = r_q + (RESW'(a_q) << mul_cnt_q);
            mul_cnt_d = mul_cnt_q + 3'd1;
            if (mul_cnt_q == 3'd6) begin
              start_d = 1'b1;
              state_d = ST_CONV;
            end
          end
          OP_SUB: begin
            neg_d   = (a_q < b_q);
            r_d     = (a_q < b_q) ? RESW'(b_q - a_q) : RESW'(a_q - b_q);
            start_d = 1'b1;
            state_d = ST_CONV;
          end
          default: begin
            neg_d   = 1'b0;
            r_d     = RESW'(a_q) + RESW'(b_q);
            start_d = 1'b1;
            state_d = ST_CONV;
          end
        endcase
      end
      ST_CONV: begin
        if (b2b_done) begin
          res_bcd_d = b2b_bcd;
          state_d   = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (key_ev && key.kind == KEY_DIGIT) begin
          a_d     = digit_ext;
          cnt_d   = 2'd1;
          b_d     = '0;
          neg_d   = 1'b0;
          state_d = ST_ENTER_A;
        end
      end
      default: state_d = ST_ENTER_A;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_ENTER_A;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      op_q      <= OP_ADD;
      r_q       <= '0;
      neg_q     <= 1'b0;
      mul_cnt_q <= '0;
      start_q   <= 1'b0;
      res_bcd_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      r_q       <= r_d;
      neg_q     <= neg_d;
      mul_cnt_q <= mul_cnt_d;
      start_q   <= start_d;
      res_bcd_q <= res_bcd_d;
    end
  end

  assign done_w = (state_q == ST_CONV) && b2b_done;

  // The converter output is shown directly in the done cycle so display and pulse coincide.
  always_comb begin
    bus.disp_bcd = 16'h0000;
    case (state_q)
      ST_ENTER_A, ST_WAIT_B: bus.disp_bcd = {8'h00, to_bcd2(a_q)};
      ST_ENTER_B, ST_CALC:   bus.disp_bcd = {8'h00, to_bcd2(b_q)};
      ST_CONV:               bus.disp_bcd = b2b_done ? b2b_bcd : {8'h00, to_bcd2(b_q)};
      ST_SHOW:               bus.disp_bcd = res_bcd_q;
      default:               bus.disp_bcd = 16'h0000;
    endcase
  end

  assign bus.disp_neg = neg_q;
  assign bus.done     = done_w;
  assign bus.busy     = ((state_q == ST_CALC) || (state_q == ST_CONV)) && !done_w;
  assign bus.state    = state_q;
endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: expected results queued at enter, checked when done pulses.
module tb_calc_sequencer;
  import calc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fails = 0;

  calc_sequencer_if bus ();

  calc_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] bcd;
    logic        neg;
    int          due;
    int          blen;
  } exp_t;

  exp_t sb[$];
  logic [8:0] dig_sc [10] = '{SC_0, SC_1, SC_2, SC_3, SC_4, SC_5, SC_6, SC_7, SC_8, SC_9};
  int   last_t;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [15:0] bcd4(input int v);
    return 16'(((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  // One key event: pulse high for exactly one cycle; returns at the negedge after the update edge.
  task automatic press(input logic [8:0] code);
    @(posedge clk); #1;
    bus.last_change       = code;
    bus.key_down_onepulse = 1'b1;
    last_t                = cyc;
    @(posedge clk); #1;
    bus.key_down_onepulse = 1'b0;
    @(negedge clk);
  endtask

  task automatic digit(input int d);
    press(dig_sc[d]);
  endtask

  task automatic enter_calc(input int a, input int b, input logic [1:0] op);
    exp_t e;
    int   res;
    int   lat;
    press(SC_ENTER);
    lat   = (op == OP_MUL) ? 22 : 16;
    res   = (op == OP_ADD) ? a + b : (op == OP_SUB) ? ((a < b) ? b - a : a - b) : a * b;
    e.bcd = bcd4(res);
    e.neg = (op == OP_SUB) && (a < b);
    e.due = last_t + lat;
    e.blen = lat - 1;
    sb.push_back(e);
    $display("enter: A=%0d B=%0d op=%0d -> expect %04h neg=%0d at cycle %0d", a, b, op, e.bcd, e.neg, e.due);
    check_eq("calc_state", 32'(bus.state), 32'(ST_CALC));
    check_eq("busy_rise", 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_empty(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check_eq("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on done and checks value, timing, busy length and the SHOW state after.
  int          busy_cnt = 0;
  logic        post_chk = 1'b0;
  logic [15:0] post_bcd = '0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt = 0;
        post_chk = 1'b0;
      end else begin
        if (post_chk) begin
          check_eq("show_state", 32'(bus.state), 32'(ST_SHOW));
          check_eq("show_hold", 32'(bus.disp_bcd), 32'(post_bcd));
          post_chk = 1'b0;
        end
        if (bus.done) begin
          if (sb.size() == 0) begin
            check_eq("unexpected_done", 32'(bus.done), 32'd0);
          end else begin
            e = sb.pop_front();
            $display("done: disp=%04h neg=%0d at cycle %0d", bus.disp_bcd, bus.disp_neg, cyc);
            check_eq("result_bcd", 32'(bus.disp_bcd), 32'(e.bcd));
            check_eq("result_neg", 32'(bus.disp_neg), 32'(e.neg));
            check_eq("done_cycle", 32'(cyc), 32'(e.due));
            check_eq("busy_len", 32'(busy_cnt), 32'(e.blen));
            check_eq("busy_at_done", 32'(bus.busy), 32'd0);
            post_chk = 1'b1;
            post_bcd = e.bcd;
          end
          busy_cnt = 0;
        end else if (bus.busy) begin
          busy_cnt++;
        end
      end
    end
  end

  initial begin
    rst                   = 1'b1;
    bus.last_change       = 9'h000;
    bus.key_down_onepulse = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_disp", 32'(bus.disp_bcd), 32'h0000);
    check_eq("rst_neg", 32'(bus.disp_neg), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_state", 32'(bus.state), 32'(ST_ENTER_A));
    @(posedge clk); #1;
    rst = 1'b0;

    // operator before any digit, third digit ignored, op replacement and enter in WAIT_B
    press(SC_ADD);
    check_eq("op_no_digit", 32'(bus.state), 32'(ST_ENTER_A));
    digit(1); digit(2); digit(3);
    check_eq("third_digit", 32'(bus.disp_bcd), 32'h0012);
    press(SC_ADD);
    check_eq("op_state", 32'(bus.state), 32'(ST_WAIT_B));
    check_eq("waitb_disp", 32'(bus.disp_bcd), 32'h0012);
    press(SC_ENTER);
    check_eq("enter_waitb", 32'(bus.state), 32'(ST_WAIT_B));
    press(SC_SUB); press(SC_MUL);
    digit(3);
    check_eq("enterb_state", 32'(bus.state), 32'(ST_ENTER_B));
    check_eq("enterb_disp", 32'(bus.disp_bcd), 32'h0003);
    enter_calc(12, 3, OP_MUL);
    wait_empty(100);

    // 12 + 34
    digit(1);
    check_eq("show_digit", 32'(bus.state), 32'(ST_ENTER_A));
    check_eq("show_digit_disp", 32'(bus.disp_bcd), 32'h0001);
    digit(2); press(SC_ADD); digit(3); digit(4);
    check_eq("b_disp", 32'(bus.disp_bcd), 32'h0034);
    enter_calc(12, 34, OP_ADD);
    wait_empty(100);

    // 5 - 9
    digit(5); press(SC_SUB); digit(9);
    enter_calc(5, 9, OP_SUB);
    wait_empty(100);

    // 99 * 99 with keys hammered while busy
    digit(9);
    check_eq("neg_cleared", 32'(bus.disp_neg), 32'd0);
    check_eq("show_9_disp", 32'(bus.disp_bcd), 32'h0009);
    digit(9); press(SC_MUL); digit(9); digit(9);
    enter_calc(99, 99, OP_MUL);
    digit(7); press(SC_ENTER); press(SC_ADD); digit(3);
    wait_empty(100);
    check_eq("busy_keys_dropped", 32'(bus.disp_bcd), 32'h9801);

    // reset five cycles into a multiply
    digit(5); press(SC_MUL); digit(6);
    enter_calc(5, 6, OP_MUL);
    sb.delete();
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_eq("abort_disp", 32'(bus.disp_bcd), 32'h0000);
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    check_eq("abort_state", 32'(bus.state), 32'(ST_ENTER_A));
    check_eq("abort_done", 32'(bus.done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (30) @(negedge clk);

    // normal operation after abort, then a fresh digit from SHOW
    digit(8); press(SC_ADD); digit(7);
    enter_calc(8, 7, OP_ADD);
    wait_empty(100);
    digit(7);
    check_eq("restart_state", 32'(bus.state), 32'(ST_ENTER_A));
    check_eq("restart_disp", 32'(bus.disp_bcd), 32'h0007);
    check_eq("restart_neg", 32'(bus.disp_neg), 32'd0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
